answer_judge: RTL and testbench

ANSWER_JUDGE -- requirements
Module: answer_judge

---
 rtl/answer_judge_if.sv | 34 +++
 rtl/answer_judge.sv | 115 +++++++++++
 tb/tb_answer_judge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/answer_judge_if.sv
// Purpose: bundles the quiz-round control inputs and judge outputs of answer_judge.
// Latency: wires only; all timing lives in answer_judge.
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface answer_judge_if #(
   parameter int unsigned SCORE_W = 8
);
   logic               start;
   logic               clearScores;
   logic [7:0]         target;
   logic               playerInputFlag;
   logic [1:0]         firstPlayerFlag;
   logic [7:0]         switchInput;
   logic               roundActive;
   logic [1:0]         winner;
   logic               winnerValid;
   logic               timeoutFlag;
   logic [3:0]         lockedOut;
   logic [SCORE_W-1:0] score0;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic [SCORE_W-1:0] score3;

   modport master (
      output start, clearScores, target, playerInputFlag, firstPlayerFlag, switchInput,
      input  roundActive, winner, winnerValid, timeoutFlag, lockedOut,
             score0, score1, score2, score3
   );

   modport slave (
      input  start, clearScores, target, playerInputFlag, firstPlayerFlag, switchInput,
      output roundActive, winner, winnerValid, timeoutFlag, lockedOut,
             score0, score1, score2, score3
   );
endinterface

// File: rtl/answer_judge.sv
// Purpose: quiz round FSM; first unlocked buzzer is judged against the target, scores kept per player.
// Latency: score/winnerValid update two cycles after the buzz-edge cycle; timeout ROUND_CYCLES after entering ARMED.
// Backpressure: none; inputs are sampled every cycle, start is ignored while a round is running.
module answer_judge #(
   parameter int unsigned ROUND_CYCLES = 500000000,
   parameter int unsigned SCORE_W      = 8
) (
   input logic           clk,
   input logic           rst,
   answer_judge_if.slave bus
);
   localparam logic [31:0] LAST_CYCLE = 32'(ROUND_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARMED, JUDGE, DONE} state_t;

   state_t             state;
   logic [31:0]        timer;
   logic [7:0]         target_q;
   logic               flag_prev;
   logic               round_active;
   logic [1:0]         winner_q;
   logic               winner_valid;
   logic               timeout_flag;
   logic [3:0]         locked_out;
   logic [SCORE_W-1:0] score_q [4];

   logic               buzz;
   logic [3:0]         winner_bit;
   logic [3:0]         locked_next;

   // Buzz detection and the lockout set that a wrong answer would produce.
   always_comb begin
      buzz        = bus.playerInputFlag && !flag_prev;
      winner_bit  = 4'b0001 << winner_q;
      locked_next = locked_out | winner_bit;
   end

   // Round FSM with registered outputs; clearScores is applied last so it beats a same-cycle match.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         timer        <= '0;
         target_q     <= '0;
         flag_prev    <= 1'b0;
         round_active <= 1'b0;
         winner_q     <= '0;
         winner_valid <= 1'b0;
         timeout_flag <= 1'b0;
         locked_out   <= '0;
         for (int i = 0; i < 4; i++) score_q[i] <= '0;
      end else begin
         // Tracked in every state so a button held before the round is not a buzz.
         flag_prev <= bus.playerInputFlag;

         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  target_q     <= bus.target;
                  locked_out   <= '0;
                  winner_valid <= 1'b0;
                  timeout_flag <= 1'b0;
                  timer        <= '0;
                  round_active <= 1'b1;
                  state        <= ARMED;
               end
            end
            ARMED: begin
               if (timer != '1) timer <= timer + 32'd1;
               if (buzz && !locked_out[bus.firstPlayerFlag]) begin
                  winner_q <= bus.firstPlayerFlag;
                  state    <= JUDGE;
               end else if (timer >= LAST_CYCLE) begin
                  // >= so an expiry that fell inside JUDGE is caught on return.
                  timeout_flag <= 1'b1;
                  round_active <= 1'b0;
                  state        <= DONE;
               end
            end
            JUDGE: begin
               if (timer != '1) timer <= timer + 32'd1;
               if (bus.switchInput == target_q) begin
                  if (score_q[winner_q] != '1) score_q[winner_q] <= score_q[winner_q] + 1'b1;
                  winner_valid <= 1'b1;
                  round_active <= 1'b0;
                  state        <= DONE;
               end else begin
                  locked_out <= locked_next;
                  if (&locked_next) begin
                     timeout_flag <= 1'b1;
                     round_active <= 1'b0;
                     state        <= DONE;
                  end else begin
                     state <= ARMED;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (bus.clearScores) begin
            for (int i = 0; i < 4; i++) score_q[i] <= '0;
         end
      end
   end

   assign bus.roundActive = round_active;
   assign bus.winner      = winner_q;
   assign bus.winnerValid = winner_valid;
   assign bus.timeoutFlag = timeout_flag;
   assign bus.lockedOut   = locked_out;
   assign bus.score0      = score_q[0];
   assign bus.score1      = score_q[1];
   assign bus.score2      = score_q[2];
   assign bus.score3      = score_q[3];
endmodule

// File: tb/tb_answer_judge.sv
// Purpose: directed bench for answer_judge with ROUND_CYCLES=100, SCORE_W=8.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; bench drives pulses directly.
module tb_answer_judge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   answer_judge_if #(.SCORE_W(8)) bus ();

   answer_judge #(.ROUND_CYCLES(100), .SCORE_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_round(input logic [7:0] t);
      bus.target = t;
      bus.start  = 1'b1;
      cyc();
      bus.start  = 1'b0;
   endtask

   // Edge cycle, then the judge cycle; outputs of the judgement are visible on return.
   task automatic press(input logic [1:0] p, input logic [7:0] sw);
      bus.playerInputFlag = 1'b1;
      bus.firstPlayerFlag = p;
      bus.switchInput     = sw;
      cyc();
      bus.playerInputFlag = 1'b0;
      cyc();
   endtask

   task automatic chk_scores(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
      chk({tag, "_s0"}, 32'(bus.score0), 32'(s0));
      chk({tag, "_s1"}, 32'(bus.score1), 32'(s1));
      chk({tag, "_s2"}, 32'(bus.score2), 32'(s2));
      chk({tag, "_s3"}, 32'(bus.score3), 32'(s3));
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start           = 1'b0;
      bus.clearScores     = 1'b0;
      bus.target          = 8'h00;
      bus.playerInputFlag = 1'b0;
      bus.firstPlayerFlag = 2'd0;
      bus.switchInput     = 8'h00;
      rst = 1'b1;
      cyc(); cyc(); cyc();
      rst = 1'b0;

      // Reset state
      chk("rst_active",  32'(bus.roundActive), 32'd0);
      chk("rst_winner",  32'(bus.winner),      32'd0);
      chk("rst_wvalid",  32'(bus.winnerValid), 32'd0);
      chk("rst_timeout", 32'(bus.timeoutFlag), 32'd0);
      chk("rst_locked",  32'(bus.lockedOut),   32'd0);
      chk_scores("rst", 8'd0, 8'd0, 8'd0, 8'd0);

      // p2 answers correctly
      start_round(8'h3C);
      chk("t1_active", 32'(bus.roundActive), 32'd1);
      bus.playerInputFlag = 1'b1;
      bus.firstPlayerFlag = 2'd1;
      bus.switchInput     = 8'h3C;
      cyc();
      chk("t1_edge_wvalid", 32'(bus.winnerValid), 32'd0);
      chk("t1_edge_score1", 32'(bus.score1),      32'd0);
      bus.playerInputFlag = 1'b0;
      cyc();
      chk("t1_winner", 32'(bus.winner),      32'd1);
      chk("t1_wvalid", 32'(bus.winnerValid), 32'd1);
      chk("t1_score1", 32'(bus.score1),      32'd1);
      chk("t1_active_done", 32'(bus.roundActive), 32'd0);

      // p1 wrong, re-buzz ignored, start ignored mid-round, p3 right
      start_round(8'h3C);
      press(2'd0, 8'h10);
      chk("t2_locked", 32'(bus.lockedOut),   32'h1);
      chk("t2_active", 32'(bus.roundActive), 32'd1);
      chk("t2_wvalid", 32'(bus.winnerValid), 32'd0);
      start_round(8'h10);
      bus.target = 8'h00;
      chk("t2_start_ignored_locked", 32'(bus.lockedOut),   32'h1);
      chk("t2_start_ignored_active", 32'(bus.roundActive), 32'd1);
      press(2'd0, 8'h3C);
      chk("t2_rebuzz_wvalid", 32'(bus.winnerValid), 32'd0);
      chk("t2_rebuzz_locked", 32'(bus.lockedOut),   32'h1);
      press(2'd2, 8'h3C);
      chk("t2_winner", 32'(bus.winner),      32'd2);
      chk("t2_wvalid", 32'(bus.winnerValid), 32'd1);
      chk_scores("t2", 8'd0, 8'd1, 8'd1, 8'd0);

      // All four wrong
      start_round(8'h55);
      press(2'd0, 8'h00);
      press(2'd1, 8'h01);
      press(2'd2, 8'h02);
      chk("t3_locked3",  32'(bus.lockedOut),   32'h7);
      chk("t3_timeout3", 32'(bus.timeoutFlag), 32'd0);
      press(2'd3, 8'h03);
      chk("t3_locked",  32'(bus.lockedOut),   32'hF);
      chk("t3_timeout", 32'(bus.timeoutFlag), 32'd1);
      chk("t3_wvalid",  32'(bus.winnerValid), 32'd0);
      chk("t3_active",  32'(bus.roundActive), 32'd0);
      chk_scores("t3", 8'd0, 8'd1, 8'd1, 8'd0);

      // Pure timeout: 100 cycles after entering ARMED
      start_round(8'hA5);
      chk("t4_restart_clears_timeout", 32'(bus.timeoutFlag), 32'd0);
      for (int i = 0; i < 99; i++) cyc();
      chk("t4_before_expiry", 32'(bus.timeoutFlag), 32'd0);
      cyc();
      chk("t4_timeout", 32'(bus.timeoutFlag), 32'd1);
      chk("t4_active",  32'(bus.roundActive), 32'd0);
      chk("t4_wvalid",  32'(bus.winnerValid), 32'd0);

      // Buzz in the expiry cycle wins
      start_round(8'hA5);
      for (int i = 0; i < 99; i++) cyc();
      bus.playerInputFlag = 1'b1;
      bus.firstPlayerFlag = 2'd3;
      bus.switchInput     = 8'hA5;
      cyc();
      chk("t5_timeout_edge", 32'(bus.timeoutFlag), 32'd0);
      chk("t5_active_edge",  32'(bus.roundActive), 32'd1);
      bus.playerInputFlag = 1'b0;
      cyc();
      chk("t5_wvalid",  32'(bus.winnerValid), 32'd1);
      chk("t5_winner",  32'(bus.winner),      32'd3);
      chk("t5_timeout", 32'(bus.timeoutFlag), 32'd0);
      chk("t5_score3",  32'(bus.score3),      32'd1);

      // Expiry inside JUDGE with a wrong answer times out on return to ARMED
      start_round(8'h77);
      for (int i = 0; i < 98; i++) cyc();
      press(2'd0, 8'h00);
      chk("t6_after_judge_timeout", 32'(bus.timeoutFlag), 32'd0);
      chk("t6_after_judge_locked",  32'(bus.lockedOut),   32'h1);
      cyc();
      chk("t6_timeout", 32'(bus.timeoutFlag), 32'd1);
      chk("t6_active",  32'(bus.roundActive), 32'd0);

      // Score saturation on p1
      for (int r = 0; r < 255; r++) begin
         start_round(8'h12);
         press(2'd0, 8'h12);
      end
      chk("t7_score0_255", 32'(bus.score0), 32'd255);
      start_round(8'h12);
      press(2'd0, 8'h12);
      chk("t7_score0_sat",  32'(bus.score0),      32'd255);
      chk("t7_wvalid_sat",  32'(bus.winnerValid), 32'd1);

      // clearScores coinciding with a JUDGE match takes precedence
      start_round(8'h21);
      bus.playerInputFlag = 1'b1;
      bus.firstPlayerFlag = 2'd1;
      bus.switchInput     = 8'h21;
      cyc();
      bus.playerInputFlag = 1'b0;
      bus.clearScores     = 1'b1;
      cyc();
      bus.clearScores     = 1'b0;
      chk("t8_wvalid", 32'(bus.winnerValid), 32'd1);
      chk_scores("t8", 8'd0, 8'd0, 8'd0, 8'd0);

      start_round(8'h44);
      press(2'd0, 8'h44);
      chk("t8_rewin_score0", 32'(bus.score0), 32'd1);

      // Button held across start is not a buzz
      bus.playerInputFlag = 1'b1;
      bus.firstPlayerFlag = 2'd1;
      bus.switchInput     = 8'h66;
      cyc();
      start_round(8'h66);
      cyc(); cyc(); cyc();
      chk("t9_held_wvalid", 32'(bus.winnerValid), 32'd0);
      chk("t9_held_active", 32'(bus.roundActive), 32'd1);
      bus.playerInputFlag = 1'b0;
      cyc();
      press(2'd2, 8'h00);
      chk("t9_locked", 32'(bus.lockedOut), 32'h4);

      // Re-press, then rst during JUDGE
      bus.playerInputFlag = 1'b1;
      bus.firstPlayerFlag = 2'd1;
      bus.switchInput     = 8'h66;
      cyc();
      bus.playerInputFlag = 1'b0;
      rst = 1'b1;
      cyc();
      chk("t10_active",  32'(bus.roundActive), 32'd0);
      chk("t10_winner",  32'(bus.winner),      32'd0);
      chk("t10_wvalid",  32'(bus.winnerValid), 32'd0);
      chk("t10_timeout", 32'(bus.timeoutFlag), 32'd0);
      chk("t10_locked",  32'(bus.lockedOut),   32'd0);
      chk_scores("t10", 8'd0, 8'd0, 8'd0, 8'd0);

      // rst beats start
      bus.target = 8'h01;
      bus.start  = 1'b1;
      cyc();
      bus.start  = 1'b0;
      rst = 1'b0;
      chk("t11_rst_over_start", 32'(bus.roundActive), 32'd0);
      cyc();
      chk("t11_idle_hold", 32'(bus.roundActive), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
